radix_counter_zz: RTL and testbench
===================================

Name: radix_counter_zz

Overview:
Parametrised successor to the two-digit hypercounter/zzer pair. It provides an N-digit counter with selectable radix and K independent divisor channels, each flagging when the count value is a nonzero multiple of its runtime divisor. A 1 kHz prescaler drives auto-stepping, and an external single-step path also advances the count. It sits between the controller and the display driver/LED animation; outputs are the packed digit nibbles, the inc/overflow pulses, and the per-channel match flags.

Parameters:
NUM_DIGITS, 2, number of 4-bit digits (1..8)
NUM_CH, 2, number of divisor channels (1..8)
DIV_W, 4, divisor width per channel
TICK_DIV, 12000, clk cycles per ms tick (>=2)
STEP_W, 11, width of step_ms

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
hold_zero  in  1  level; clears count and residues, blocks stepping
radix  in  2  0 decimal, 1 octal, 2 hex, 3 binary
run  in  1  1 = auto-step from ms ticks
step_req  in  1  one-cycle pulse; single step (honoured when run=0)
step_ms  in  STEP_W  ms ticks between auto steps, minus 1
divisor  in  NUM_CH*DIV_W  channel c divisor at [c*DIV_W +: DIV_W]
digits  out  NUM_DIGITS*4  digit d at [d*4 +: 4], d=0 least significant
inc  out  1  one-cycle pulse coincident with each new count value
overflow  out  1  one-cycle pulse when the count wraps to all-zero
match  out  NUM_CH  level; bit c = count nonzero and count mod divisor[c] == 0

Behaviour:
- Reset (rst_n=0 at a clk edge): digits=0, match=0, inc=0, overflow=0, residues=0, prescaler reloaded to TICK_DIV-1, ms counter=0. The reset value of every output is 0.
- Prescaler: down-counter; tick is a one-cycle pulse every TICK_DIV clks. It free-runs independently of hold_zero and run.
- Step source:
  - run=1: step fires on a tick when ms counter==0; ms counter then reloads step_ms. Otherwise ms counter decrements on each tick. Result: first step on the first tick after hold/reset, then every step_ms+1 ticks; step_ms=0 steps on every tick.
  - run=0: ms counter holds at 0; step_req fires a step in the same cycle it is high.
  - run=1: step_req is ignored.
- Step: the increment is registered, so digits, inc and match all update on the clk edge after the step condition. Latency is 1 cycle.
  - Ripple increment: digit 0 increments. Any digit equal to radix max (9/7/F/1) becomes 0 and carries to the next digit.
  - Carry out of the top digit sets all digits to 0 and pulses overflow in the same cycle as inc.
- Residues: channel c keeps residue r_c in [0, divisor[c]-1].
  - On a step, r_c = (r_c == divisor[c]-1) ? 0 : r_c+1.
  - match[c] is registered and equals (new r_c == 0) && count nonzero && divisor[c] != 0.
  - On overflow, all residues are forced to 0 and match=0, because radix^N is not generally divisible.
  - divisor 0: channel disabled, match[c]=0, residue held at 0.
  - divisor 1: match on every nonzero value.
- Divisor change mid-count: the residue is not recomputed. The channel is defined only after the next hold_zero/reset; the bench must apply hold_zero when changing a divisor.
- Radix change: any cycle where radix differs from its registered copy is treated as hold_zero for that cycle. Digits never exceed the radix max.
- hold_zero=1:
  - Each cycle: digits=0, residues=0, match=0, inc=0, overflow=0, ms counter=0.
  - hold_zero has priority over a simultaneous step, step_req, or overflow.
- inc and overflow never stay high for 2 consecutive cycles, unless TICK_DIV ≥ 2 and run=0 with back-to-back step_req pulses (one step per pulse).

Decomposition:
- Shared package (radix_pkg):
  - radix codes R_DECIMAL/R_OCTAL/R_HEX/R_BINARY
  - function radix_max(radix) returning a 4-bit value
- The Override codes stay in the display package and are not used here.
- One natural sub-module, mod_residue (one per channel, generate loop). Inputs: clk, rst_n, clear, step, divisor. Outputs: residue_zero, enabled.
- Prescaler and digit ripple stay inline.

Test Plan:
- TICK_DIV=4, decimal, run=1, step_ms=0, divisors 3,5:
  - inc every 4 clks
  - value 15 -> digits=8'h15, match=2'b11
  - value 9 -> match=2'b01
  - value 10 -> match=2'b10
- Decimal, step to 99 then one more step -> digits=8'h00, inc=1 and overflow=1 in the same cycle, match=00. The next step gives 01 with match=00; value 03 gives match=01.
- NUM_DIGITS=2, binary, run=0, 4 step_req pulses -> digits 01,10,11,00 (8'h01,8'h10,8'h11,8'h00). Overflow pulses on the 4th step only.
- Hex, count at 8'h2A, radix changed to octal -> next cycle digits=0, match=0, no inc. Stepping resumes from 01.
- hold_zero asserted on the same cycle as a step at value 14 -> digits=0, inc=0, overflow=0. With run=1 the first step comes on the first tick after release.
- rst_n=0 mid-count (value 0x37, match=01) -> after the reset edge all outputs are 0. Divisor 0 on channel 1 -> match[1] stays 0 across 20 steps.

Source files
------------

// File: rtl/radix_counter_zz_pkg.sv
// -----------------------------------------------------------------------------
// radix_counter_zz_pkg
// Shared definitions for the radix counter: radix codes and the per-radix
// maximum digit value used by the ripple increment.
// -----------------------------------------------------------------------------
package radix_counter_zz_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        R_DECIMAL = 2'd0,
        R_OCTAL   = 2'd1,
        R_HEX     = 2'd2,
        R_BINARY  = 2'd3
    } radix_t;

    // Largest legal digit for a radix code; a digit at this value wraps to 0
    // and carries on the next increment.
    function automatic logic [DIGIT_W-1:0] radix_max(input logic [1:0] radix);
        logic [DIGIT_W-1:0] m;
        case (radix)
            R_DECIMAL: m = 4'd9;
            R_OCTAL:   m = 4'd7;
            R_HEX:     m = 4'hF;
            default:   m = 4'd1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/radix_counter_zz_if.sv
// -----------------------------------------------------------------------------
// radix_counter_zz_if
// Control/status bundle between the controller and the radix counter.
//   hold_zero : level, clears count and residues, blocks stepping
//   radix     : 0 decimal, 1 octal, 2 hex, 3 binary
//   run       : 1 = auto-step from ms ticks
//   step_req  : one-cycle single-step pulse (used when run=0)
//   step_ms   : ms ticks between auto steps, minus 1
//   divisor   : channel c divisor at [c*DIV_W +: DIV_W]
//   digits    : packed digit nibbles, digit 0 least significant
//   inc       : pulse with each new count value
//   overflow  : pulse when the count wraps to all-zero
//   match     : per-channel "nonzero multiple of divisor" level
// master = controller side, slave = counter side.
// -----------------------------------------------------------------------------
interface radix_counter_zz_if #(
    parameter int NUM_DIGITS = 2,
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 4,
    parameter int STEP_W     = 11
);
    logic                      hold_zero;
    logic [1:0]                radix;
    logic                      run;
    logic                      step_req;
    logic [STEP_W-1:0]         step_ms;
    logic [NUM_CH*DIV_W-1:0]   divisor;
    logic [NUM_DIGITS*4-1:0]   digits;
    logic                      inc;
    logic                      overflow;
    logic [NUM_CH-1:0]         match;

    modport master (
        output hold_zero, radix, run, step_req, step_ms, divisor,
        input  digits, inc, overflow, match
    );

    modport slave (
        input  hold_zero, radix, run, step_req, step_ms, divisor,
        output digits, inc, overflow, match
    );
endinterface

// File: rtl/radix_counter_zz_mod_residue.sv
// -----------------------------------------------------------------------------
// mod_residue
// Tracks the count modulo one runtime divisor by stepping a residue in
// lock-step with the main counter.
//   clk, rst_n   : clock, synchronous active-low reset
//   clear        : force residue to 0 (hold, radix change or count wrap)
//   step         : counter advanced this cycle
//   divisor      : channel divisor, 0 disables the channel
//   residue_zero : registered residue equals 0
//   enabled      : registered "divisor was nonzero" at the last update
// -----------------------------------------------------------------------------
module mod_residue #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [DIV_W-1:0] divisor,
    output logic             residue_zero,
    output logic             enabled
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] residue_p1;
    logic             en_p1;

    // Residue stage: updates on the same edge as the digits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            residue_p1 <= '0;
            en_p1      <= 1'b0;
        end else if (clear) begin
            residue_p1 <= '0;
            en_p1      <= (divisor != '0);
        end else if (step) begin
            en_p1 <= (divisor != '0);
            // >= rather than == keeps the residue bounded if the divisor
            // shrank without a clear.
            if (divisor == '0 || residue_p1 >= divisor - ONE)
                residue_p1 <= '0;
            else
                residue_p1 <= residue_p1 + ONE;
        end
    end

    assign residue_zero = (residue_p1 == '0);
    assign enabled      = en_p1;

endmodule

// File: rtl/radix_counter_zz.sv
// -----------------------------------------------------------------------------
// radix_counter_zz
// N-digit counter with selectable radix and NUM_CH divisor channels. A ms
// prescaler drives auto-stepping (run=1); step_req single-steps when run=0.
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : radix_counter_zz_if.slave (controls in, digits/inc/overflow/match out)
// All outputs update on the edge after the step condition.
// -----------------------------------------------------------------------------
module radix_counter_zz
    import radix_counter_zz_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 4,
    parameter int TICK_DIV   = 12000,
    parameter int STEP_W     = 11
) (
    input  logic clk,
    input  logic rst_n,
    radix_counter_zz_if.slave bus
);
    localparam int                  PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LOAD = PRESC_W'(TICK_DIV - 1);
    localparam int                  CNT_W      = NUM_DIGITS * DIGIT_W;

    logic [PRESC_W-1:0] presc_p0;
    logic [STEP_W-1:0]  ms_p0;
    logic [1:0]         radix_q;
    logic               tick_p0;
    logic               clear_p0;
    logic               step_p0;
    logic               wrap_p0;
    logic [DIGIT_W-1:0] dmax_p0;
    logic [CNT_W-1:0]   digits_nxt_p0;

    logic [CNT_W-1:0]   digits_p1;
    logic               inc_p1;
    logic               ovf_p1;
    logic [NUM_CH-1:0]  res_zero_p1;
    logic [NUM_CH-1:0]  ch_en_p1;

    // Step decision stage
    assign tick_p0  = (presc_p0 == '0);
    // A radix change acts as a one-cycle hold so digits never exceed the new max.
    assign clear_p0 = bus.hold_zero || (bus.radix != radix_q);
    assign step_p0  = !clear_p0 &&
                      (bus.run ? (tick_p0 && ms_p0 == '0) : bus.step_req);

    always_ff @(posedge clk) begin
        if (!rst_n)
            presc_p0 <= PRESC_LOAD;
        else if (tick_p0)
            presc_p0 <= PRESC_LOAD;
        else
            presc_p0 <= presc_p0 - PRESC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ms_p0 <= '0;
        else if (clear_p0 || !bus.run)
            ms_p0 <= '0;
        else if (tick_p0)
            ms_p0 <= (ms_p0 == '0) ? bus.step_ms : ms_p0 - STEP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            radix_q <= 2'd0;
        else
            radix_q <= bus.radix;
    end

    // Ripple increment: a carry out of the top digit leaves every digit at 0,
    // which is exactly the wrapped value.
    always_comb begin
        logic carry;
        dmax_p0       = radix_max(bus.radix);
        digits_nxt_p0 = digits_p1;
        carry         = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (digits_p1[d*DIGIT_W +: DIGIT_W] >= dmax_p0) begin
                    digits_nxt_p0[d*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    digits_nxt_p0[d*DIGIT_W +: DIGIT_W] =
                        digits_p1[d*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        wrap_p0 = carry;
    end

    // Count register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_p1 <= '0;
            inc_p1    <= 1'b0;
            ovf_p1    <= 1'b0;
        end else if (clear_p0) begin
            digits_p1 <= '0;
            inc_p1    <= 1'b0;
            ovf_p1    <= 1'b0;
        end else if (step_p0) begin
            digits_p1 <= digits_nxt_p0;
            inc_p1    <= 1'b1;
            ovf_p1    <= wrap_p0;
        end else begin
            inc_p1    <= 1'b0;
            ovf_p1    <= 1'b0;
        end
    end

    // On wrap the residues restart at 0 since radix^N is generally not a
    // multiple of the divisor.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mod_residue #(
            .DIV_W(DIV_W)
        ) u_res (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear        (clear_p0 || (step_p0 && wrap_p0)),
            .step         (step_p0),
            .divisor      (bus.divisor[c*DIV_W +: DIV_W]),
            .residue_zero (res_zero_p1[c]),
            .enabled      (ch_en_p1[c])
        );
    end

    assign bus.digits   = digits_p1;
    assign bus.inc      = inc_p1;
    assign bus.overflow = ovf_p1;
    assign bus.match    = res_zero_p1 & ch_en_p1 & {NUM_CH{|digits_p1}};

endmodule

// File: tb/tb_radix_counter_zz.sv
// -----------------------------------------------------------------------------
// tb_radix_counter_zz
// Directed and randomized bench for radix_counter_zz (TICK_DIV=4, 2 digits,
// 2 channels). Expected values come from an integer model of the count.
// -----------------------------------------------------------------------------
module tb_radix_counter_zz;
    localparam int NUM_DIGITS = 2;
    localparam int NUM_CH     = 2;
    localparam int DIV_W      = 4;
    localparam int TICK_DIV   = 4;
    localparam int STEP_W     = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    radix_counter_zz_if #(
        .NUM_DIGITS(NUM_DIGITS), .NUM_CH(NUM_CH), .DIV_W(DIV_W), .STEP_W(STEP_W)
    ) bus ();

    radix_counter_zz #(
        .NUM_DIGITS(NUM_DIGITS), .NUM_CH(NUM_CH), .DIV_W(DIV_W),
        .TICK_DIV(TICK_DIV), .STEP_W(STEP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: count as a plain integer in the current base.
    int base = 10;
    int cnt  = 0;
    int dv[NUM_CH];
    logic last_ovf;

    function automatic int base_of(input logic [1:0] r);
        case (r)
            2'd0:    return 10;
            2'd1:    return 8;
            2'd2:    return 16;
            default: return 2;
        endcase
    endfunction

    function automatic logic [NUM_DIGITS*4-1:0] to_digits(input int v, input int b);
        logic [NUM_DIGITS*4-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % b);
            x = x / b;
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_match();
        logic [NUM_CH-1:0] m;
        for (int c = 0; c < NUM_CH; c++)
            m[c] = (cnt != 0) && ((dv[c] != 0) ? ((cnt % dv[c]) == 0) : 1'b0);
        return m;
    endfunction

    task automatic model_adv();
        cnt      = (cnt + 1) % (base ** NUM_DIGITS);
        last_ovf = (cnt == 0);
    endtask

    task automatic chk_out(input string tag, input logic e_inc, input logic e_ovf);
        logic [NUM_DIGITS*4-1:0] ed;
        logic [NUM_CH-1:0]       em;
        ed = to_digits(cnt, base);
        em = exp_match();
        checks++;
        assert (bus.digits === ed) else begin
            errors++; $error("FAIL %s digits: got %h expected %h", tag, bus.digits, ed);
        end
        checks++;
        assert (bus.inc === e_inc) else begin
            errors++; $error("FAIL %s inc: got %b expected %b", tag, bus.inc, e_inc);
        end
        checks++;
        assert (bus.overflow === e_ovf) else begin
            errors++; $error("FAIL %s overflow: got %b expected %b", tag, bus.overflow, e_ovf);
        end
        checks++;
        assert (bus.match === em) else begin
            errors++; $error("FAIL %s match: got %b expected %b", tag, bus.match, em);
        end
    endtask

    task automatic set_divs(input int d0, input int d1);
        dv[0] = d0;
        dv[1] = d1;
        bus.divisor = {DIV_W'(d1), DIV_W'(d0)};
    endtask

    // One hold_zero cycle; the model restarts from 0.
    task automatic clear_cycle(input string tag);
        bus.hold_zero = 1'b1;
        @(negedge clk);
        bus.hold_zero = 1'b0;
        cnt  = 0;
        base = base_of(bus.radix);
        chk_out(tag, 1'b0, 1'b0);
    endtask

    task automatic pulse_step(input string tag);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        model_adv();
        chk_out(tag, 1'b1, last_ovf);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        chk_out(tag, 1'b0, 1'b0);
    endtask

    // Wait (bounded) for the next auto step and check it; n = cycles waited.
    task automatic auto_step(input string tag, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.inc !== 1'b1 && n < maxc);
        checks++;
        assert (bus.inc === 1'b1) else begin
            errors++; $error("FAIL %s wait_inc: got inc=%b after %0d cycles expected 1", tag, bus.inc, n);
        end
        model_adv();
        chk_out(tag, 1'b1, last_ovf);
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bin_seq [4];
        int n;
        bin_seq = '{8'h01, 8'h10, 8'h11, 8'h00};

        bus.hold_zero = 1'b0;
        bus.radix     = 2'd0;
        bus.run       = 1'b0;
        bus.step_req  = 1'b0;
        bus.step_ms   = '0;
        set_divs(3, 5);
        last_ovf = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        idle("post_reset");

        // Decimal single steps up to 99, then wrap
        for (int i = 1; i <= 99; i++) begin
            pulse_step("dec");
            if (cnt == 15) begin
                chk_int("dec15_digits", int'(bus.digits), 'h15);
                chk_int("dec15_match", int'(bus.match), 3);
            end
            if (cnt == 9)  chk_int("dec9_match", int'(bus.match), 1);
            if (cnt == 10) chk_int("dec10_match", int'(bus.match), 2);
        end
        pulse_step("dec_wrap");
        chk_int("dec_wrap_ovf", int'(bus.overflow), 1);
        chk_int("dec_wrap_digits", int'(bus.digits), 0);
        idle("after_wrap");
        pulse_step("wrap_01");
        chk_int("wrap_01_match", int'(bus.match), 0);
        pulse_step("wrap_02");
        pulse_step("wrap_03");
        chk_int("wrap_03_match", int'(bus.match), 1);

        // Binary, radix change acts as a clear
        bus.radix = 2'd3;
        @(negedge clk);
        cnt = 0; base = 2;
        chk_out("radix_bin", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pulse_step("bin");
            chk_int("bin_seq", int'(bus.digits), int'(bin_seq[i]));
            chk_int("bin_ovf", int'(bus.overflow), (i == 3) ? 1 : 0);
        end

        // Hex to 0x2A, then switch to octal together with a step request
        bus.radix = 2'd2;
        @(negedge clk);
        cnt = 0; base = 16;
        chk_out("radix_hex", 1'b0, 1'b0);
        for (int i = 0; i < 42; i++) pulse_step("hex");
        chk_int("hex_2a", int'(bus.digits), 'h2A);
        bus.radix    = 2'd1;
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        cnt = 0; base = 8;
        chk_out("radix_oct", 1'b0, 1'b0);
        pulse_step("oct_01");

        // hold_zero beats a simultaneous step at value 14
        bus.radix = 2'd0;
        @(negedge clk);
        cnt = 0; base = 10;
        chk_out("radix_dec", 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) pulse_step("dec14");
        bus.hold_zero = 1'b1;
        bus.step_req  = 1'b1;
        @(negedge clk);
        bus.step_req  = 1'b0;
        bus.hold_zero = 1'b0;
        cnt = 0;
        chk_out("hold_step", 1'b0, 1'b0);

        // Auto stepping, step_ms=0: first step on first tick, then every TICK_DIV
        bus.run = 1'b1;
        clear_cycle("run_hold");
        auto_step("run_first", TICK_DIV, n);
        for (int i = 0; i < 16; i++) begin
            auto_step("run_ms0", 3 * TICK_DIV, n);
            chk_int("run_ms0_period", n, TICK_DIV);
        end

        // step_ms=2: period 3 ticks; step_req ignored while running
        bus.step_ms = STEP_W'(2);
        clear_cycle("run_hold2");
        auto_step("run2_first", TICK_DIV, n);
        auto_step("run_ms2", 6 * TICK_DIV, n);
        chk_int("run_ms2_period", n, 3 * TICK_DIV);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        chk_out("run_ignore_req", 1'b0, 1'b0);
        auto_step("run_ms2b", 6 * TICK_DIV, n);
        chk_int("run_ms2b_period", n, 3 * TICK_DIV - 1);
        bus.run     = 1'b0;
        bus.step_ms = '0;

        // Reset mid-count at 0x37 with match=01
        bus.radix = 2'd2;
        set_divs(5, 3);
        clear_cycle("hex_hold");
        for (int i = 0; i < 55; i++) pulse_step("hex37");
        chk_int("hex37_digits", int'(bus.digits), 'h37);
        chk_int("hex37_match", int'(bus.match), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        chk_out("rst_mid", 1'b0, 1'b0);
        idle("rst_mid_idle");

        // Channel 1 disabled
        bus.radix = 2'd0;
        set_divs(3, 0);
        clear_cycle("div0_hold");
        for (int i = 0; i < 20; i++) begin
            pulse_step("div0");
            chk_int("div0_match1", int'(bus.match[1]), 0);
        end

        // Randomized radix/divisors/step gaps against the model
        for (int it = 0; it < 8; it++) begin
            bus.radix = 2'($urandom_range(0, 3));
            set_divs(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            clear_cycle("rnd_hold");
            n = int'($urandom_range(1, 40));
            for (int s = 0; s < n; s++) begin
                pulse_step("rnd_step");
                repeat ($urandom_range(0, 2)) idle("rnd_idle");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
